permu_opqueue_sched: RTL and testbench

//  Shares one permutation operand queue between NrReq requesters (LUT/permute sequencer slots).

---
 rtl/permu_opqueue_sched.sv | 147 ++++++++++++++
 tb/tb_permu_opqueue_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/permu_opqueue_sched.sv
// Round-robin scheduler sharing one permutation operand queue between several requesters.
// Issues credit-limited VRF reads and reports completion once the queue pops the command.
module permu_opqueue_sched #(
    parameter int unsigned NrReq     = 2,
    parameter int unsigned AddrWidth = 9,
    parameter int unsigned CntWidth  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic [NrReq-1:0]           req_valid_i,
    input  logic [NrReq*AddrWidth-1:0] req_addr_i,
    input  logic [NrReq*CntWidth-1:0]  req_words_i,
    input  logic [NrReq-1:0]           req_fu_i,
    output logic [NrReq-1:0]           req_ready_o,
    output logic [NrReq-1:0]           req_done_o,
    output logic                       opq_cmd_valid_o,
    output logic [CntWidth-1:0]        opq_cmd_words_o,
    output logic                       opq_cmd_fu_o,
    input  logic                       opq_ready_i,
    input  logic                       opq_cmd_pop_i,
    output logic                       vrf_req_o,
    output logic [AddrWidth-1:0]       vrf_addr_o,
    input  logic                       vrf_gnt_i,
    output logic                       operand_issued_o,
    output logic                       busy_o
);

    localparam int unsigned PtrWidth = (NrReq > 1) ? $clog2(NrReq) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]           r_state;
    logic [PtrWidth-1:0]  r_rrPtr;
    logic [PtrWidth-1:0]  r_grantIdx;
    logic [AddrWidth-1:0] r_baseAddr;
    logic [CntWidth-1:0]  r_words;
    logic [CntWidth-1:0]  r_issuedCnt;
    logic                 r_earlyPop;

    logic                 w_grantFound;
    logic [PtrWidth-1:0]  w_grantIdx;
    logic [PtrWidth-1:0]  w_candIdx;
    logic [PtrWidth-1:0]  w_nextPtr;
    logic [CntWidth-1:0]  w_grantWords;
    logic [AddrWidth-1:0] w_grantAddr;
    logic                 w_grant;
    logic                 w_issueReq;
    logic                 w_xfer;
    logic                 w_lastXfer;
    logic                 w_done;

    // First valid requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        w_grantFound = 1'b0;
        w_grantIdx   = '0;
        w_candIdx    = '0;
        for (int unsigned k = 0; k < NrReq; k++) begin
            w_candIdx = PtrWidth'((32'(r_rrPtr) + k) % NrReq);
            if (!w_grantFound && req_valid_i[w_candIdx]) begin
                w_grantFound = 1'b1;
                w_grantIdx   = w_candIdx;
            end
        end
    end

    assign w_nextPtr    = (w_grantIdx == PtrWidth'(NrReq - 1)) ? '0 : w_grantIdx + PtrWidth'(1);
    assign w_grantWords = req_words_i[w_grantIdx*CntWidth +: CntWidth];
    assign w_grantAddr  = req_addr_i[w_grantIdx*AddrWidth +: AddrWidth];

    // Flush overrides every event of its cycle, so it masks grant, request and done.
    assign w_grant    = (r_state == StIdle) && w_grantFound && !flush_i;
    assign w_issueReq = (r_state == StIssue) && opq_ready_i && !flush_i;
    assign w_xfer     = w_issueReq && vrf_gnt_i;
    assign w_lastXfer = w_xfer && ((r_issuedCnt + CntWidth'(1)) == r_words);
    assign w_done     = (r_state == StDrain) && !flush_i && (opq_cmd_pop_i || r_earlyPop);

    always_comb begin
        for (int unsigned k = 0; k < NrReq; k++) begin
            req_ready_o[k] = w_grant && (w_grantIdx == PtrWidth'(k));
            req_done_o[k]  = w_done && (r_grantIdx == PtrWidth'(k));
        end
    end

    assign opq_cmd_valid_o  = w_grant;
    assign opq_cmd_words_o  = w_grant ? (w_grantWords - CntWidth'(1)) : '0;
    assign opq_cmd_fu_o     = w_grant && req_fu_i[w_grantIdx];
    assign vrf_req_o        = w_issueReq;
    assign vrf_addr_o       = (r_state == StIssue) ? (r_baseAddr + AddrWidth'(r_issuedCnt)) : '0;
    assign operand_issued_o = w_xfer;
    assign busy_o           = (r_state != StIdle);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_rrPtr     <= '0;
            r_grantIdx  <= '0;
            r_baseAddr  <= '0;
            r_words     <= '0;
            r_issuedCnt <= '0;
            r_earlyPop  <= 1'b0;
        end else if (flush_i) begin
            r_state     <= StIdle;
            r_issuedCnt <= '0;
            r_earlyPop  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_grant) begin
                        r_state     <= StIssue;
                        r_rrPtr     <= w_nextPtr;
                        r_grantIdx  <= w_grantIdx;
                        r_baseAddr  <= w_grantAddr;
                        r_words     <= w_grantWords;
                        r_issuedCnt <= '0;
                        r_earlyPop  <= 1'b0;
                    end
                end
                StIssue: begin
                    // A pop can overtake the last read; remember it so DRAIN exits at once.
                    if (opq_cmd_pop_i) begin
                        r_earlyPop <= 1'b1;
                    end
                    if (w_xfer) begin
                        r_issuedCnt <= r_issuedCnt + CntWidth'(1);
                    end
                    if (w_lastXfer) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (w_done) begin
                        r_state     <= StIdle;
                        r_issuedCnt <= '0;
                        r_earlyPop  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_permu_opqueue_sched.sv
// Scoreboard bench for permu_opqueue_sched: a transaction-level model predicts grants,
// read addresses and completions; a negedge monitor compares them against the DUT.
module tb_permu_opqueue_sched;

    localparam int NrReq     = 2;
    localparam int AddrWidth = 9;
    localparam int CntWidth  = 8;

    logic                       clk_i = 1'b0;
    logic                       rst_ni = 1'b0;
    logic                       flush_i = 1'b0;
    logic [NrReq-1:0]           req_valid_i = '0;
    logic [NrReq*AddrWidth-1:0] req_addr_i = '0;
    logic [NrReq*CntWidth-1:0]  req_words_i = '0;
    logic [NrReq-1:0]           req_fu_i = '0;
    logic [NrReq-1:0]           req_ready_o;
    logic [NrReq-1:0]           req_done_o;
    logic                       opq_cmd_valid_o;
    logic [CntWidth-1:0]        opq_cmd_words_o;
    logic                       opq_cmd_fu_o;
    logic                       opq_ready_i = 1'b0;
    logic                       opq_cmd_pop_i = 1'b0;
    logic                       vrf_req_o;
    logic [AddrWidth-1:0]       vrf_addr_o;
    logic                       vrf_gnt_i = 1'b0;
    logic                       operand_issued_o;
    logic                       busy_o;

    always #5 clk_i = ~clk_i;

    permu_opqueue_sched #(
        .NrReq    (NrReq),
        .AddrWidth(AddrWidth),
        .CntWidth (CntWidth)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_addr_i      (req_addr_i),
        .req_words_i     (req_words_i),
        .req_fu_i        (req_fu_i),
        .req_ready_o     (req_ready_o),
        .req_done_o      (req_done_o),
        .opq_cmd_valid_o (opq_cmd_valid_o),
        .opq_cmd_words_o (opq_cmd_words_o),
        .opq_cmd_fu_o    (opq_cmd_fu_o),
        .opq_ready_i     (opq_ready_i),
        .opq_cmd_pop_i   (opq_cmd_pop_i),
        .vrf_req_o       (vrf_req_o),
        .vrf_addr_o      (vrf_addr_o),
        .vrf_gnt_i       (vrf_gnt_i),
        .operand_issued_o(operand_issued_o),
        .busy_o          (busy_o)
    );

    typedef struct packed {
        logic [NrReq-1:0] ready;
        logic [NrReq-1:0] done;
        logic             cmdValid;
        logic             vrfReq;
        logic             issued;
        logic             busy;
    } flags_t;

    typedef struct packed {
        logic [CntWidth-1:0] words;
        logic                fu;
    } cmd_t;

    int checks = 0;
    int errors = 0;
    bit monEn = 1'b0;

    flags_t               cycQ[$];
    cmd_t                 cmdQ[$];
    logic [AddrWidth-1:0] addrQ[$];

    // Requester-side pending commands, held until the model says they were accepted.
    bit                  pending[NrReq];
    logic [AddrWidth-1:0] rqAddr[NrReq];
    logic [CntWidth-1:0]  rqWords[NrReq];
    logic                 rqFu[NrReq];

    // Transaction-level model of the scheduler.
    bit mActive;
    bit mPopSeen;
    int mOwner;
    int mPtr;
    int mBase;
    int mSent;
    int mTotal;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic newCmd(input int i, input logic [AddrWidth-1:0] a, input logic [CntWidth-1:0] w, input logic f);
        pending[i] = 1'b1;
        rqAddr[i]  = a;
        rqWords[i] = w;
        rqFu[i]    = f;
    endtask

    task automatic modelReset();
        mActive  = 1'b0;
        mPopSeen = 1'b0;
        mOwner   = 0;
        mPtr     = 0;
        mBase    = 0;
        mSent    = 0;
        mTotal   = 0;
        for (int i = 0; i < NrReq; i++) pending[i] = 1'b0;
    endtask

    // Drives one cycle of inputs, predicts this cycle's behaviour, advances to next cycle.
    task automatic applyStimulus(input logic rdy, input logic gnt, input logic pop, input logic flush);
        flags_t e;
        int     w;
        int     idx;
        for (int i = 0; i < NrReq; i++) begin
            req_valid_i[i]                         = pending[i];
            req_addr_i[i*AddrWidth +: AddrWidth]   = rqAddr[i];
            req_words_i[i*CntWidth +: CntWidth]    = rqWords[i];
            req_fu_i[i]                            = rqFu[i];
        end
        opq_ready_i   = rdy;
        vrf_gnt_i     = gnt;
        opq_cmd_pop_i = pop;
        flush_i       = flush;

        e      = '0;
        e.busy = mActive;
        if (flush) begin
            mActive  = 1'b0;
            mPopSeen = 1'b0;
        end else if (!mActive) begin
            w = -1;
            for (int k = 0; k < NrReq; k++) begin
                idx = (mPtr + k) % NrReq;
                if (w < 0 && pending[idx]) w = idx;
            end
            if (w >= 0) begin
                e.ready[w] = 1'b1;
                e.cmdValid = 1'b1;
                cmdQ.push_back(cmd_t'{words: rqWords[w] - 8'd1, fu: rqFu[w]});
                mActive    = 1'b1;
                mPopSeen   = 1'b0;
                mOwner     = w;
                mBase      = int'(rqAddr[w]);
                mTotal     = int'(rqWords[w]);
                mSent      = 0;
                mPtr       = (w + 1) % NrReq;
                pending[w] = 1'b0;
            end
        end else if (mSent < mTotal) begin
            if (rdy) begin
                e.vrfReq = 1'b1;
                if (gnt) begin
                    e.issued = 1'b1;
                    addrQ.push_back(AddrWidth'((mBase + mSent) % (1 << AddrWidth)));
                    mSent++;
                end
            end
            if (pop) mPopSeen = 1'b1;
        end else if (pop || mPopSeen) begin
            e.done[mOwner] = 1'b1;
            mActive        = 1'b0;
            mPopSeen       = 1'b0;
        end
        cycQ.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic drainAll();
        for (int c = 0; c < 300; c++) begin
            if (!mActive && !pending[0] && !pending[1]) break;
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        end
    endtask

    // Monitor: compares per-cycle control flags and pops value queues on output pulses.
    always @(negedge clk_i) begin
        flags_t e;
        flags_t a;
        cmd_t   c;
        if (monEn && cycQ.size() > 0) begin
            e = cycQ.pop_front();
            a = {req_ready_o, req_done_o, opq_cmd_valid_o, vrf_req_o, operand_issued_o, busy_o};
            checkOutput("cycle flags", 32'(a), 32'(e));
            if (vrf_req_o) checkOutput("vrf_req with opq_ready low", 32'(opq_ready_i), 32'd1);
            if (opq_cmd_valid_o) begin
                if (cmdQ.size() == 0) begin
                    checkOutput("unexpected cmd push", 32'd1, 32'd0);
                end else begin
                    c = cmdQ.pop_front();
                    checkOutput("cmd words/fu", 32'({opq_cmd_words_o, opq_cmd_fu_o}), 32'(c));
                end
            end
            if (operand_issued_o) begin
                if (addrQ.size() == 0) begin
                    checkOutput("unexpected operand issue", 32'd1, 32'd0);
                end else begin
                    checkOutput("vrf address", 32'(vrf_addr_o), 32'(addrQ.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        for (int i = 0; i < NrReq; i++) begin
            rqAddr[i]  = '0;
            rqWords[i] = 8'd1;
            rqFu[i]    = 1'b0;
        end
        #12;
        checkOutput("reset outputs", 32'({req_ready_o, req_done_o, opq_cmd_valid_o, opq_cmd_words_o,
                    opq_cmd_fu_o, vrf_req_o, vrf_addr_o, operand_issued_o, busy_o}), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        monEn  = 1'b1;

        $display("[TB] basic 4-word command");
        newCmd(0, 9'h010, 8'd4, 1'b1);
        for (int t = 0; t <= 8; t++) applyStimulus(1'b1, 1'b1, t == 7, 1'b0);

        $display("[TB] continuous requests alternate");
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NrReq; i++)
                if (!pending[i]) newCmd(i, 9'($urandom_range(0, 511)), 8'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end
        drainAll();

        $display("[TB] queue credit stall");
        newCmd(1, 9'h080, 8'd3, 1'b0);
        for (int t = 0; t <= 9; t++) applyStimulus(!(t >= 2 && t <= 4), 1'b1, t == 9, 1'b0);
        drainAll();

        $display("[TB] VRF grant toggling");
        newCmd(0, 9'h040, 8'd3, 1'b1);
        for (int t = 0; t <= 8; t++) applyStimulus(1'b1, t % 2 == 1, t == 8, 1'b0);
        drainAll();

        $display("[TB] address wrap");
        newCmd(0, 9'h1FF, 8'd2, 1'b0);
        for (int t = 0; t <= 5; t++) applyStimulus(1'b1, 1'b1, t == 5, 1'b0);
        drainAll();

        $display("[TB] flush mid-issue, then early pop");
        newCmd(0, 9'h100, 8'd5, 1'b0);
        for (int t = 0; t <= 9; t++) begin
            if (t == 3) newCmd(1, 9'h0F0, 8'd2, 1'b1);
            applyStimulus(1'b1, 1'b1, t == 5, t == 3);
        end
        drainAll();

        $display("[TB] asynchronous reset mid-operation");
        newCmd(0, 9'h020, 8'd6, 1'b0);
        for (int t = 0; t < 3; t++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        monEn = 1'b0;
        req_valid_i = '0;
        opq_ready_i = 1'b0; vrf_gnt_i = 1'b0; opq_cmd_pop_i = 1'b0; flush_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        checkOutput("mid-op reset outputs", 32'({req_ready_o, req_done_o, opq_cmd_valid_o, vrf_req_o,
                    vrf_addr_o, operand_issued_o, busy_o}), 32'd0);
        modelReset();
        cycQ.delete();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        monEn  = 1'b1;
        newCmd(0, 9'h030, 8'd1, 1'b0);
        newCmd(1, 9'h031, 8'd1, 1'b1);
        drainAll();

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NrReq; i++)
                if (!pending[i] && $urandom_range(0, 99) < 30)
                    newCmd(i, 9'($urandom_range(0, 511)), 8'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
            applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 9) < 2, $urandom_range(0, 99) < 2);
        end
        drainAll();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        checkOutput("cmd queue drained", 32'(cmdQ.size()), 32'd0);
        checkOutput("addr queue drained", 32'(addrQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
